// File: rtl/commit_retire_unit.sv
// -----------------------------------------------------------------------------
// commit_retire_unit
//   Retires uops from the ROB head and owns the architectural state.
//   - Holds the retirement RAT (RRAT), updated one cycle after each retire.
//   - Returns superseded physical registers to the free list.
//   - Releases committed stores to memory.
//   - On an exception at the head it runs RUN -> FLUSH -> RESTORE -> RUN:
//     - FLUSH squashes the pipeline and redirects fetch to TRAP_VEC.
//     - RESTORE streams the RRAT into the rename RAT, one entry per cycle.
//
// Ports
//   clk, rst               clock; asynchronous active-low reset
//   commit_*               ROB head handshake and payload (pop on valid&&ready)
//   fl_free_*              free-list return of the superseded physical register
//   st_release             pulse: oldest store may write memory
//   flush_all              pulse: squash ROB/RS/rename/LSQ
//   redirect_valid/_pc     fetch redirect, coincident with flush_all
//   rat_rst_*              rename-RAT restore stream and completion pulse
//   busy                   high while not in RUN
//   minstret               retired-instruction count (only with the macro)
//
// Configuration
//   COMMIT_RETIRE_PERF_CNT_EN: when defined, adds the 64-bit minstret counter.
// -----------------------------------------------------------------------------
module commit_retire_unit #(
  parameter int          LOG_REGS = 32,
  parameter int          PHY_REGS = 64,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          commit_valid,
  output logic                          commit_ready,
  input  logic [$clog2(LOG_REGS)-1:0]   commit_arch_rd,
  input  logic [$clog2(PHY_REGS)-1:0]   commit_new_prf,
  input  logic [$clog2(PHY_REGS)-1:0]   commit_old_prf,
  input  logic [31:0]                   commit_pc,
  input  logic                          commit_is_store,
  input  logic                          commit_exception,
  output logic                          fl_free_valid,
  output logic [$clog2(PHY_REGS)-1:0]   fl_free_prf,
  input  logic                          fl_free_ready,
  output logic                          st_release,
  output logic                          flush_all,
  output logic                          redirect_valid,
  output logic [31:0]                   redirect_pc,
  output logic                          rat_rst_valid,
  output logic [$clog2(LOG_REGS)-1:0]   rat_rst_arch,
  output logic [$clog2(PHY_REGS)-1:0]   rat_rst_prf,
  output logic                          rat_rst_done,
  output logic                          busy
`ifdef COMMIT_RETIRE_PERF_CNT_EN
  ,
  output logic [63:0]                   minstret
`endif
);

  localparam int AW = $clog2(LOG_REGS);
  localparam int PW = $clog2(PHY_REGS);
  localparam logic [AW-1:0] LAST_ARCH = AW'(LOG_REGS - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RESTORE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    rrat_q [LOG_REGS];

  logic             need_free_s;
  logic             handshake_s;
  logic             rrat_we_s;
  logic             retire_s;

  // The PC is carried for trace/debug consumers only; nothing here needs it.
  logic             unused_pc_s;
  assign unused_pc_s = ^commit_pc;

  // A commit needs a free-list slot only when it supersedes a real mapping.
  assign need_free_s = !commit_is_store && (commit_arch_rd != '0) && !commit_exception;

  // Next-state, counter and all combinational outputs.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    commit_ready   = 1'b0;
    fl_free_valid  = 1'b0;
    fl_free_prf    = '0;
    st_release     = 1'b0;
    flush_all      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    rat_rst_valid  = 1'b0;
    rat_rst_arch   = '0;
    rat_rst_prf    = '0;
    rat_rst_done   = 1'b0;
    rrat_we_s      = 1'b0;
    retire_s       = 1'b0;
    handshake_s    = 1'b0;

    case (state_q)
      ST_RUN: begin
        // Exceptions never wait on the free list; they free nothing.
        commit_ready  = commit_exception | !need_free_s | fl_free_ready;
        fl_free_valid = commit_valid & need_free_s;
        fl_free_prf   = commit_old_prf;
        handshake_s   = commit_valid & commit_ready;
        if (handshake_s) begin
          if (commit_exception) begin
            state_d = ST_FLUSH;
          end else begin
            retire_s   = 1'b1;
            rrat_we_s  = need_free_s;
            st_release = commit_is_store;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        flush_all      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = TRAP_VEC;
        state_d        = ST_RESTORE;
      end
      ST_RESTORE: begin
        rat_rst_valid = 1'b1;
        rat_rst_arch  = cnt_q;
        rat_rst_prf   = rrat_q[cnt_q];
        if (cnt_q == LAST_ARCH) begin
          cnt_d        = '0;
          rat_rst_done = 1'b1;
          state_d      = ST_RUN;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q != ST_RUN);

  // State and restore counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Retirement RAT: identity after reset, written on non-exception retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LOG_REGS; i++) begin
        rrat_q[i] <= PW'(i);
      end
    end else if (rrat_we_s) begin
      rrat_q[commit_arch_rd] <= commit_new_prf;
    end
  end

`ifdef COMMIT_RETIRE_PERF_CNT_EN
  // Retired-instruction counter; wraps naturally at 2^64.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      minstret <= 64'd0;
    end else if (retire_s) begin
      minstret <= minstret + 64'd1;
    end
  end
`else
  logic unused_retire_s;
  assign unused_retire_s = retire_s;
`endif

endmodule
